// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register bus adapter.
package reg_bus_pkg;

    // Adapter FSM: IDLE accepts a request, RSP presents the response.
    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } state_e;

    // Every register occupies one 32-bit word of byte address space.
    localparam int unsigned REG_BYTES = 4;

    // Number of byte-offset bits inside one register word.
    localparam int unsigned OFF_W = $clog2(REG_BYTES);

endpackage

// File: rtl/reg_addr_decode.sv
// Combinational decode of a bus access: one-hot register select plus error flag.
// An access is rejected when it is misaligned, lands beyond the last register,
// or is a write that does not enable every byte lane.
module reg_addr_decode
    import reg_bus_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic [AW-1:0]    addr_i,
    input  logic [DW/8-1:0]  be_i,
    input  logic             we_i,
    output logic [NREGS-1:0] hit_o,
    output logic             err_o
);

    localparam int IDX_W = AW - OFF_W;

    logic [IDX_W-1:0] idx;
    logic [31:0]      idx_ext;
    logic             misaligned;
    logic             out_of_range;
    logic             partial_wr;

    assign idx          = addr_i[AW-1:OFF_W];
    assign idx_ext      = 32'(idx);
    assign misaligned   = |addr_i[OFF_W-1:0];
    assign out_of_range = (idx_ext >= 32'(NREGS));
    assign partial_wr   = we_i & ~(&be_i);
    assign err_o        = misaligned | out_of_range | partial_wr;

    // Select exactly one register for a legal access, none for an errored one.
    always_comb begin
        hit_o = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (idx_ext == 32'(k)) begin
                hit_o[k] = 1'b1;
            end
        end
        if (err_o) begin
            hit_o = '0;
        end
    end

endmodule

// File: rtl/reg_bus_adapter.sv
// Bridges a request/grant + valid/ready register bus onto a bank of register
// slices. Each accepted access produces a single-cycle we/re strobe to the
// addressed slice and one response that is held until the requester takes it.
// Read data is sampled on the accept edge so read-clear side effects, which
// land one cycle later, never disturb the returned value.
module reg_bus_adapter
    import reg_bus_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                req_i,
    output logic                gnt_o,
    input  logic                req_we_i,
    input  logic [AW-1:0]       req_addr_i,
    input  logic [DW-1:0]       req_wdata_i,
    input  logic [DW/8-1:0]     req_be_i,

    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DW-1:0]       rsp_rdata_o,
    output logic                rsp_err_o,

    output logic [NREGS-1:0]    reg_we_o,
    output logic [NREGS-1:0]    reg_re_o,
    output logic [DW-1:0]       reg_wd_o,
    input  logic [NREGS*DW-1:0] reg_qs_i
);

    state_e           state_q, state_d;
    logic [NREGS-1:0] we_q, we_d;
    logic [NREGS-1:0] re_q, re_d;
    logic [DW-1:0]    wd_q, wd_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [NREGS-1:0] hit;
    logic             dec_err;
    logic [DW-1:0]    rd_sel;

    reg_addr_decode #(
        .NREGS (NREGS),
        .AW    (AW),
        .DW    (DW)
    ) u_decode (
        .addr_i (req_addr_i),
        .be_i   (req_be_i),
        .we_i   (req_we_i),
        .hit_o  (hit),
        .err_o  (dec_err)
    );

    // Read-data mux driven by the one-hot select; an errored access selects nothing and reads zero.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (hit[k]) begin
                rd_sel = rd_sel | reg_qs_i[k*DW +: DW];
            end
        end
    end

    // Next-state logic: capture the access on accept, strobes last only the first RSP cycle.
    always_comb begin
        state_d = state_q;
        we_d    = '0;
        re_d    = '0;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = RSP;
                    err_d   = dec_err;
                    if (req_we_i) begin
                        we_d    = hit;
                        wd_d    = req_wdata_i;
                        rdata_d = '0;
                    end else begin
                        re_d    = hit;
                        rdata_d = rd_sel;
                    end
                end
            end
            RSP: begin
                // New requests are ignored here; the requester keeps req_i up until granted.
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, dropping any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= '0;
            re_q    <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            re_q    <= re_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign gnt_o       = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign reg_we_o    = we_q;
    assign reg_re_o    = re_q;
    assign reg_wd_o    = wd_q;

endmodule

// File: tb/tb_reg_bus_adapter.sv
// Self-checking bench for reg_bus_adapter (NREGS=8, AW=8, DW=32).
// Register 1 is modelled as a read-clear slice; all others are plain storage.
module tb_reg_bus_adapter;

    localparam int NREGS = 8;
    localparam int RC_IDX = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic         gnt;
    logic         req_we = 1'b0;
    logic [7:0]   req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic [3:0]   req_be = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [7:0]   reg_we;
    logic [7:0]   reg_re;
    logic [31:0]  reg_wd;
    logic [255:0] reg_qs;

    logic [31:0]  slice [NREGS];
    logic [31:0]  mdl [NREGS];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    reg_bus_adapter #(.NREGS(NREGS), .AW(8), .DW(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_wd_o    (reg_wd),
        .reg_qs_i    (reg_qs)
    );

    function automatic logic [31:0] init_val(input int k);
        if (k == RC_IDX) return 32'h0000_00FF;
        if (k == 3)      return 32'h1234_5678;
        return 32'h1000_0000 + 32'(k);
    endfunction

    // Register slices seen by the DUT: plain storage, register 1 clears on read strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) slice[k] <= init_val(k);
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (reg_we[k]) slice[k] <= reg_wd;
                if (k == RC_IDX && reg_re[k]) slice[k] <= 32'h0;
            end
        end
    end

    always_comb begin
        reg_qs = '0;
        for (int k = 0; k < NREGS; k++) reg_qs[k*32 +: 32] = slice[k];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Reference model: access outcome from the address/enable rules.
    function automatic logic ref_err(input logic we, input logic [7:0] addr, input logic [3:0] be);
        return (addr[1:0] != 2'b00) || (int'(addr[7:2]) >= NREGS) || (we && be != 4'hF);
    endfunction

    task automatic reset_model();
        for (int k = 0; k < NREGS; k++) mdl[k] = init_val(k);
    endtask

    task automatic model_update(input logic we, input logic [7:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata);
        int idx;
        idx = int'(addr[7:2]);
        if (!ref_err(we, addr, be)) begin
            if (we) mdl[idx] = wdata;
            else if (idx == RC_IDX) mdl[idx] = 32'h0;
        end
    endtask

    // One complete access: starts and ends one time unit after a rising edge.
    task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int dly, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic [7:0] exp_wep,
                          input logic [7:0] exp_rep, input string tag);
        int n;
        req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        while (gnt !== 1'b1 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " gnt_idle"}, 64'(gnt), 64'(1));
        @(posedge clk); #1;
        req = 1'b0;
        model_update(we, addr, be, wdata);
        chk({tag, " valid"}, 64'(rsp_valid), 64'(1));
        chk({tag, " gnt_rsp"}, 64'(gnt), 64'(0));
        chk({tag, " err"}, 64'(rsp_err), 64'(exp_err));
        chk({tag, " rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
        chk({tag, " we_pulse"}, 64'(reg_we), 64'(exp_wep));
        chk({tag, " re_pulse"}, 64'(reg_re), 64'(exp_rep));
        if (exp_wep != 8'h0) chk({tag, " wd"}, 64'(reg_wd), 64'(wdata));
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, 64'(rsp_valid), 64'(1));
            chk({tag, " hold_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
            chk({tag, " hold_err"}, 64'(rsp_err), 64'(exp_err));
            chk({tag, " hold_pulses"}, 64'({reg_we, reg_re}), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " done_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, " done_gnt"}, 64'(gnt), 64'(1));
        chk({tag, " done_pulses"}, 64'({reg_we, reg_re}), 64'(0));
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  wep;
        logic [7:0]  rep;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic        r_we, r_err;
        logic [7:0]  r_addr, r_wep, r_rep;
        logic [31:0] r_wdata, r_rdata;
        logic [3:0]  r_be;

        //             we    addr   wdata          be     err   rdata          wep    rep
        tbl[0]  = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        8'h04, 8'h00};
        tbl[1]  = '{1'b0, 8'h0C, 32'h0,        4'hF, 1'b0, 32'h12345678, 8'h00, 8'h08};
        tbl[2]  = '{1'b0, 8'h08, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 8'h00, 8'h04};
        tbl[3]  = '{1'b0, 8'h20, 32'h0,        4'hF, 1'b1, 32'h0,        8'h00, 8'h00};
        tbl[4]  = '{1'b0, 8'h05, 32'h0,        4'hF, 1'b1, 32'h0,        8'h00, 8'h00};
        tbl[5]  = '{1'b1, 8'h10, 32'hCAFE0001, 4'h3, 1'b1, 32'h0,        8'h00, 8'h00};
        tbl[6]  = '{1'b0, 8'h04, 32'h0,        4'hF, 1'b0, 32'h000000FF, 8'h00, 8'h02};
        tbl[7]  = '{1'b0, 8'h04, 32'h0,        4'hF, 1'b0, 32'h00000000, 8'h00, 8'h02};
        tbl[8]  = '{1'b1, 8'h1C, 32'hA5A50001, 4'hF, 1'b0, 32'h0,        8'h80, 8'h00};
        tbl[9]  = '{1'b0, 8'h1C, 32'h0,        4'hF, 1'b0, 32'hA5A50001, 8'h00, 8'h80};
        tbl[10] = '{1'b1, 8'hFC, 32'h11111111, 4'hF, 1'b1, 32'h0,        8'h00, 8'h00};
        tbl[11] = '{1'b0, 8'h00, 32'h0,        4'hF, 1'b0, 32'h10000000, 8'h00, 8'h01};

        // Reset state, checked before any active clock edge while reset is held.
        reset_model();
        #3;
        chk("rst gnt", 64'(gnt), 64'(1));
        chk("rst valid", 64'(rsp_valid), 64'(0));
        chk("rst err", 64'(rsp_err), 64'(0));
        chk("rst rdata", 64'(rsp_rdata), 64'(0));
        chk("rst pulses", 64'({reg_we, reg_re}), 64'(0));
        chk("rst wd", 64'(reg_wd), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, i % 3, tbl[i].err,
                   tbl[i].rdata, tbl[i].wep, tbl[i].rep, $sformatf("vec%0d", i));
        end

        // Backpressure: response held 5 cycles while a second request waits.
        req = 1'b1; req_we = 1'b0; req_addr = 8'h0C; req_be = 4'hF;
        chk("bp gnt_idle", 64'(gnt), 64'(1));
        @(posedge clk); #1;
        model_update(1'b0, 8'h0C, 4'hF, 32'h0);
        req_we = 1'b1; req_addr = 8'h00; req_wdata = 32'h0BADF00D;
        chk("bp rdata", 64'(rsp_rdata), 64'(mdl[3]));
        chk("bp re_pulse", 64'(reg_re), 64'(8'h08));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp hold_valid", 64'(rsp_valid), 64'(1));
            chk("bp hold_rdata", 64'(rsp_rdata), 64'(mdl[3]));
            chk("bp hold_gnt", 64'(gnt), 64'(0));
            chk("bp hold_pulses", 64'({reg_we, reg_re}), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp idle_gnt", 64'(gnt), 64'(1));
        chk("bp idle_valid", 64'(rsp_valid), 64'(0));
        chk("bp idle_no_we", 64'(reg_we), 64'(0));
        @(posedge clk); #1;
        req = 1'b0;
        model_update(1'b1, 8'h00, 4'hF, 32'h0BADF00D);
        chk("bp second_we", 64'(reg_we), 64'(8'h01));
        chk("bp second_wd", 64'(reg_wd), 64'(32'h0BADF00D));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset while a read response is pending: outputs clear without a clock edge.
        req = 1'b1; req_we = 1'b0; req_addr = 8'h00; req_be = 4'hF;
        @(posedge clk); #1;
        req = 1'b0;
        chk("rsprst pre_rdata", 64'(rsp_rdata), 64'(32'h0BADF00D));
        #1 rst_n = 1'b0;
        #1;
        chk("rsprst valid", 64'(rsp_valid), 64'(0));
        chk("rsprst gnt", 64'(gnt), 64'(1));
        chk("rsprst rdata", 64'(rsp_rdata), 64'(0));
        chk("rsprst wd", 64'(reg_wd), 64'(0));
        chk("rsprst pulses", 64'({reg_we, reg_re}), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        reset_model();
        @(posedge clk); #1;

        // Reset while a write strobe is live: the strobe vanishes and never reappears.
        req = 1'b1; req_we = 1'b1; req_addr = 8'h14; req_wdata = 32'h55AA55AA; req_be = 4'hF;
        @(posedge clk); #1;
        req = 1'b0;
        chk("wrrst pre_we", 64'(reg_we), 64'(8'h20));
        #1 rst_n = 1'b0;
        #1;
        chk("wrrst we", 64'(reg_we), 64'(0));
        chk("wrrst valid", 64'(rsp_valid), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("wrrst post_pulses", 64'({reg_we, reg_re}), 64'(0));
            chk("wrrst post_valid", 64'(rsp_valid), 64'(0));
        end

        // Randomised accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            r_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) r_addr = 8'($urandom);
            else r_addr = {3'b000, 3'($urandom_range(0, NREGS - 1)), 2'b00};
            r_be = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            r_wdata = $urandom;
            r_err = ref_err(r_we, r_addr, r_be);
            r_rdata = (r_err || r_we) ? 32'h0 : mdl[r_addr[4:2]];
            r_wep = (!r_err && r_we) ? (8'h01 << r_addr[4:2]) : 8'h00;
            r_rep = (!r_err && !r_we) ? (8'h01 << r_addr[4:2]) : 8'h00;
            access(r_we, r_addr, r_wdata, r_be, $urandom_range(0, 3), r_err, r_rdata,
                   r_wep, r_rep, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_bus_adapter.md
REG_BUS_ADAPTER -- requirements
Module: reg_bus_adapter

Interface
REQ-001 SHALL have parameter NREGS, default 8: number of 32-bit registers served (1..64).
REQ-002 SHALL have parameter AW, default 8: byte address width; requires 2^(AW-2) >= NREGS.
REQ-003 SHALL have parameter DW, default 32: data width; only 32 is supported.
REQ-004 clk_i  input  1  clock; all logic on the rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_i  input  1  bus request valid.
REQ-007 gnt_o  output  1  request accepted this cycle.
REQ-008 req_we_i  input  1  1 = write, 0 = read.
REQ-009 req_addr_i  input  AW  byte address.
REQ-010 req_wdata_i  input  DW  write data.
REQ-011 req_be_i  input  DW/8  byte enables.
REQ-012 rsp_valid_o  output  1  response valid.
REQ-013 rsp_ready_i  input  1  response consumed.
REQ-014 rsp_rdata_o  output  DW  read data.
REQ-015 rsp_err_o  output  1  access error.
REQ-016 reg_we_o  output  NREGS  one-hot write pulse; register k drives slice we.
REQ-017 reg_re_o  output  NREGS  one-hot read pulse; drives we of read-clear (RC) slices.
REQ-018 reg_wd_o  output  DW  write data to all slices.
REQ-019 reg_qs_i  input  NREGS*DW  slice qs values; register k occupies bits [k*DW +: DW].

Function
REQ-020 SHALL implement a two-state FSM, IDLE and RSP.
REQ-021 In IDLE, gnt_o SHALL be 1; in RSP, gnt_o SHALL be 0.
REQ-022 An accept is a cycle T with req_i=1 in IDLE; the FSM SHALL then enter RSP at T+1.
REQ-023 index = req_addr_i[AW-1:2]; the access SHALL be errored when any of the following holds:
  - req_addr_i[1:0] != 0;
  - index >= NREGS;
  - a write has req_be_i != all-ones.
REQ-024 A non-errored write SHALL pulse reg_we_o[index] high for exactly cycle T+1, with reg_wd_o = the req_wdata_i captured at T.
REQ-025 A non-errored read SHALL pulse reg_re_o[index] high for exactly cycle T+1.
REQ-026 A read SHALL capture reg_qs_i[index] at the T edge into rsp_rdata_o, so an RC clear (visible at T+2) never corrupts the returned value.
REQ-027 rsp_valid_o SHALL be 1 throughout RSP; rsp_rdata_o and rsp_err_o SHALL hold stable until rsp_ready_i=1.
REQ-028 In RSP with rsp_ready_i=1, the FSM SHALL return to IDLE next cycle; maximum throughput is one access per 2 cycles.
REQ-029 An errored access SHALL produce no reg_we_o/reg_re_o pulse, rsp_err_o=1 and rsp_rdata_o=0.
REQ-030 Writes SHALL return rsp_rdata_o=0.
REQ-031 reg_we_o and reg_re_o SHALL never both be nonzero, and each SHALL have at most one bit set.
REQ-032 req_i in RSP SHALL be ignored; the requester holds it until granted.

Reset
REQ-033 While rst_ni=0, the following SHALL hold immediately, independent of clk_i:
  - state = IDLE;
  - gnt_o = 1;
  - rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0;
  - reg_we_o = 0, reg_re_o = 0, reg_wd_o = 0.
REQ-034 Reset during RSP SHALL drop the pending response; no pulse SHALL be emitted after reset release without a new accept.

Structure
REQ-035 Package reg_bus_pkg SHALL hold the FSM state enum (IDLE, RSP) and the constant REG_BYTES = 4.
REQ-036 A sub-module reg_addr_decode is natural: address/be/we in, one-hot hit plus error out, purely combinational.
REQ-037 No other sub-module.

Verification
REQ-038 Write 0xDEADBEEF to 0x08 with be=0xF -> gnt at T; reg_we_o=0x04 only at T+1; reg_wd_o=0xDEADBEEF; rsp_err_o=0.
REQ-039 Read 0x0C with reg_qs_i[3]=0x12345678 -> rsp_rdata_o=0x12345678 at T+1; reg_re_o=0x08 for one cycle only.
REQ-040 Read of 0x20 (NREGS=8), read of 0x05, and write with be=0x3 -> rsp_err_o=1, rsp_rdata_o=0, no pulses.
REQ-041 rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable, gnt_o=0, second req_i not accepted until a cycle after ready.
REQ-042 RC read of reg 1 holding 0xFF (slice clears on we) -> response 0xFF; a following read returns 0x00.
REQ-043 rst_ni asserted in RSP -> rsp_valid_o=0 immediately; no reg pulse after release.
